// File: rtl/fetch_load_ctrl_if.sv
// Bus bundle between the fetch/load controller, the program loader, the core
// fetch port and the instruction memory.
interface fetch_load_ctrl_if #(
   parameter int ADDR_W = 4
);
   logic              Load_Start;
   logic              Load_Valid;
   logic [7:0]        Load_Data;
   logic              Load_Ready;
   logic              Load_Done;
   logic              Fetch_Req;
   logic [7:0]        Fetch_PC;
   logic              Fetch_Ready;
   logic              Fetch_Valid;
   logic [7:0]        Fetch_Instr;
   logic              Fetch_Err;
   logic [ADDR_W-1:0] Mem_Addr;
   logic [7:0]        Mem_WData;
   logic              Mem_WE;
   logic [7:0]        Mem_RData;
   logic [ADDR_W:0]   Prog_Len;
   logic [1:0]        State;

   modport slave (
      input  Load_Start, Load_Valid, Load_Data, Load_Done,
      input  Fetch_Req, Fetch_PC, Mem_RData,
      output Load_Ready, Fetch_Ready, Fetch_Valid, Fetch_Instr, Fetch_Err,
      output Mem_Addr, Mem_WData, Mem_WE, Prog_Len, State
   );

   modport master (
      output Load_Start, Load_Valid, Load_Data, Load_Done,
      output Fetch_Req, Fetch_PC, Mem_RData,
      input  Load_Ready, Fetch_Ready, Fetch_Valid, Fetch_Instr, Fetch_Err,
      input  Mem_Addr, Mem_WData, Mem_WE, Prog_Len, State
   );
endinterface

// File: rtl/fetch_load_ctrl.sv
// Program loader / instruction fetch controller in front of a combinational-read memory.
// Optional macro IMEM_BOUNDS_CHECK_EN: fetches at or beyond Prog_Len return 8'h00 with Fetch_Err.
module fetch_load_ctrl #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                Clk,
   input  logic                Reset_n,
   fetch_load_ctrl_if.slave    bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10
   } state_t;

   localparam logic [ADDR_W:0] LAST_LEN = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);

   state_t            state_r;
   logic [ADDR_W:0]   prog_len_r;
   logic              fetch_valid_r;
   logic [7:0]        fetch_instr_r;
   logic              fetch_err_r;

   logic              load_ready_s;
   logic              write_s;
   logic              fetch_ready_s;
   logic              fetch_acc_s;
   logic              oob_s;
   logic [7:0]        fetch_data_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic              unused_pc_s;

   assign unused_pc_s = &{1'b0, bus.Fetch_PC[7:ADDR_W]};

   // Handshake decode, memory port steering and fetch data selection
   always_comb begin
      load_ready_s  = (state_r == ST_LOAD) && !bus.Load_Start;
      write_s       = load_ready_s && bus.Load_Valid;
      fetch_ready_s = (state_r == ST_RUN) && !bus.Load_Start;
      fetch_acc_s   = fetch_ready_s && bus.Fetch_Req;
      mem_addr_s    = bus.Fetch_PC[ADDR_W-1:0];
      if (write_s) begin
         mem_addr_s = prog_len_r[ADDR_W-1:0];
      end else begin
         mem_addr_s = bus.Fetch_PC[ADDR_W-1:0];
      end
`ifdef IMEM_BOUNDS_CHECK_EN
      oob_s = (bus.Fetch_PC >= 8'(prog_len_r));
      if (oob_s) begin
         fetch_data_s = 8'h00;
      end else begin
         fetch_data_s = bus.Mem_RData;
      end
`else
      oob_s        = 1'b0;
      fetch_data_s = bus.Mem_RData;
`endif
   end

   // Mode FSM, load byte counter and registered fetch response
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r       <= ST_IDLE;
         prog_len_r    <= {(ADDR_W+1){1'b0}};
         fetch_valid_r <= 1'b0;
         fetch_instr_r <= 8'h00;
         fetch_err_r   <= 1'b0;
      end else if (bus.Load_Start) begin
         // A new load preempts everything, including a fetch presented this cycle
         state_r       <= ST_LOAD;
         prog_len_r    <= {(ADDR_W+1){1'b0}};
         fetch_valid_r <= 1'b0;
         fetch_err_r   <= 1'b0;
      end else begin
         fetch_valid_r <= fetch_acc_s;
         fetch_err_r   <= fetch_acc_s && oob_s;
         if (fetch_acc_s) begin
            fetch_instr_r <= fetch_data_s;
         end
         case (state_r)
            ST_IDLE: state_r <= ST_IDLE;
            ST_LOAD: begin
               if (write_s) begin
                  prog_len_r <= prog_len_r + LEN_ONE;
               end
               if (bus.Load_Done || (write_s && (prog_len_r == LAST_LEN))) begin
                  state_r <= ST_RUN;
               end
            end
            ST_RUN:  state_r <= ST_RUN;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign bus.Load_Ready  = load_ready_s;
   assign bus.Fetch_Ready = fetch_ready_s;
   assign bus.Fetch_Valid = fetch_valid_r;
   assign bus.Fetch_Instr = fetch_instr_r;
   assign bus.Fetch_Err   = fetch_err_r;
   assign bus.Mem_Addr    = mem_addr_s;
   assign bus.Mem_WData   = bus.Load_Data;
   assign bus.Mem_WE      = write_s;
   assign bus.Prog_Len    = prog_len_r;
   assign bus.State       = state_r;
endmodule

// File: tb/tb_fetch_load_ctrl.sv
// Randomized scoreboard bench for fetch_load_ctrl against a program-level reference model.
module tb_fetch_load_ctrl;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   typedef struct {
      logic [7:0] instr;
      logic       err;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   fetch_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
   fetch_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   // Physical memory attached to the controller; preloaded with a known pattern
   logic [7:0] phys_mem [DEPTH];
   logic       mem_inited = 1'b0;
   assign bus.Mem_RData = phys_mem[bus.Mem_Addr];
   always @(posedge Clk) begin
      if (!mem_inited) begin
         for (int i = 0; i < DEPTH; i++) phys_mem[i] <= 8'hA0 + 8'(i);
         mem_inited <= 1'b1;
      end else if (bus.Mem_WE) begin
         phys_mem[bus.Mem_Addr] <= bus.Mem_WData;
      end
   end

   // Reference model: program image, loaded length and mode (0 idle, 1 load, 2 run)
   logic [7:0] ref_mem [DEPTH];
   int         ref_len;
   int         ref_state;
   exp_t       exp_q [$];
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t expect_fetch(input logic [7:0] pc);
      exp_t e;
      e.instr = ref_mem[int'(pc) % DEPTH];
      e.err   = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
      if (int'(pc) >= ref_len) begin
         e.instr = 8'h00;
         e.err   = 1'b1;
      end
`endif
      return e;
   endfunction

   // Monitor: every Fetch_Valid pulse must match the oldest expected response
   exp_t       mon_e;
   logic [7:0] hold_instr = 8'h00;
   always @(negedge Clk) begin
      if (!Reset_n) begin
         hold_instr <= 8'h00;
      end else if (bus.Fetch_Valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got Fetch_Valid=1 expected 0 at %0t", $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("fetch_instr", int'(bus.Fetch_Instr), int'(mon_e.instr));
            chk("fetch_err", int'(bus.Fetch_Err), int'(mon_e.err));
            hold_instr <= mon_e.instr;
         end
      end else begin
         chk("instr_hold", int'(bus.Fetch_Instr), int'(hold_instr));
      end
   end

   task automatic clear_inputs();
      bus.Load_Start = 1'b0;
      bus.Load_Valid = 1'b0;
      bus.Load_Data  = 8'h00;
      bus.Load_Done  = 1'b0;
      bus.Fetch_Req  = 1'b0;
      bus.Fetch_PC   = 8'h00;
   endtask

   task automatic status();
      chk("state", int'(bus.State), ref_state);
      chk("prog_len", int'(bus.Prog_Len), ref_len);
   endtask

   task automatic load_start(input bit with_fetch);
      bus.Load_Start = 1'b1;
      bus.Fetch_Req  = with_fetch;
      @(negedge Clk);
      status();
      chk("load_ready_on_start", int'(bus.Load_Ready), 0);
      chk("fetch_ready_on_start", int'(bus.Fetch_Ready), 0);
      chk("mem_we_on_start", int'(bus.Mem_WE), 0);
      @(posedge Clk);
      ref_state = 1;
      ref_len   = 0;
      #1 clear_inputs();
   endtask

   task automatic load_byte(input logic [7:0] b, input bit done);
      bus.Load_Valid = 1'b1;
      bus.Load_Data  = b;
      bus.Load_Done  = done;
      @(negedge Clk);
      status();
      chk("load_ready", int'(bus.Load_Ready), 1);
      chk("mem_we", int'(bus.Mem_WE), 1);
      chk("mem_addr_wr", int'(bus.Mem_Addr), ref_len);
      chk("mem_wdata", int'(bus.Mem_WData), int'(b));
      @(posedge Clk);
      ref_mem[ref_len] = b;
      ref_len++;
      if (done || ref_len == DEPTH) ref_state = 2;
      #1 clear_inputs();
   endtask

   task automatic load_done_only();
      bus.Load_Done = 1'b1;
      @(negedge Clk);
      status();
      chk("mem_we_done", int'(bus.Mem_WE), 0);
      @(posedge Clk);
      if (ref_state == 1) ref_state = 2;
      #1 clear_inputs();
   endtask

   // One cycle with no accepted transfer; optionally presents stray requests
   task automatic gap_cycle(input bit stray_valid, input bit stray_req);
      bus.Load_Valid = stray_valid && (ref_state != 1);
      bus.Fetch_Req  = stray_req && (ref_state != 2);
      @(negedge Clk);
      status();
      chk("mem_we_gap", int'(bus.Mem_WE), 0);
      chk("load_ready_gap", int'(bus.Load_Ready), int'(ref_state == 1));
      chk("fetch_ready_gap", int'(bus.Fetch_Ready), int'(ref_state == 2));
      @(posedge Clk);
      #1 clear_inputs();
   endtask

   task automatic fetch(input logic [7:0] pc);
      bus.Fetch_Req = 1'b1;
      bus.Fetch_PC  = pc;
      @(negedge Clk);
      status();
      chk("fetch_ready", int'(bus.Fetch_Ready), 1);
      chk("mem_we_run", int'(bus.Mem_WE), 0);
      chk("mem_addr_rd", int'(bus.Mem_Addr), int'(pc) % DEPTH);
      exp_q.push_back(expect_fetch(pc));
      @(posedge Clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] prog [6];
      int n;
      prog[0] = 8'h2B; prog[1] = 8'h6A; prog[2] = 8'h63;
      prog[3] = 8'hC1; prog[4] = 8'h14; prog[5] = 8'h55;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hA0 + 8'(i);
      ref_len   = 0;
      ref_state = 0;
      clear_inputs();
      Reset_n = 1'b0;
      #3;
      chk("rst_state", int'(bus.State), 0);
      chk("rst_prog_len", int'(bus.Prog_Len), 0);
      chk("rst_fetch_valid", int'(bus.Fetch_Valid), 0);
      chk("rst_fetch_instr", int'(bus.Fetch_Instr), 0);
      chk("rst_fetch_err", int'(bus.Fetch_Err), 0);
      chk("rst_load_ready", int'(bus.Load_Ready), 0);
      chk("rst_fetch_ready", int'(bus.Fetch_Ready), 0);
      chk("rst_mem_we", int'(bus.Mem_WE), 0);
      @(posedge Clk);
      @(posedge Clk);
      #1 Reset_n = 1'b1;
      gap_cycle(1'b1, 1'b1);

      // Six-byte program, explicit Load_Done, then back-to-back fetches
      load_start(1'b0);
      for (int i = 0; i < 6; i++) load_byte(prog[i], 1'b0);
      load_done_only();
      for (int i = 0; i < 6; i++) fetch(8'(i));
      gap_cycle(1'b1, 1'b0);
      gap_cycle(1'b0, 1'b0);
      fetch(8'h09);
      gap_cycle(1'b0, 1'b0);

      // Fetch immediately followed by a load start carrying a fetch request
      fetch(8'h03);
      load_start(1'b1);
      gap_cycle(1'b0, 1'b1);
      gap_cycle(1'b0, 1'b0);

      // Full memory without Load_Done
      for (int i = 0; i < DEPTH; i++) load_byte(8'($urandom_range(0, 255)), 1'b0);
      gap_cycle(1'b1, 1'b0);
      for (int i = 0; i < 20; i++) fetch(8'(i));
      gap_cycle(1'b0, 1'b0);

      // Last byte coincides with Load_Done
      load_start(1'b0);
      load_byte(8'h11, 1'b0);
      load_byte(8'h22, 1'b0);
      load_byte(8'h33, 1'b1);
      fetch(8'h02);
      fetch(8'h03);
      gap_cycle(1'b0, 1'b0);

      // Empty program
      load_start(1'b0);
      load_done_only();
      fetch(8'h00);
      gap_cycle(1'b0, 1'b0);

      // Reset in the middle of a load
      load_start(1'b0);
      for (int i = 0; i < 3; i++) load_byte(8'h70 + 8'(i), 1'b0);
      bus.Load_Valid = 1'b1;
      bus.Load_Data  = 8'h7F;
      Reset_n = 1'b0;
      #1;
      chk("midrst_state", int'(bus.State), 0);
      chk("midrst_prog_len", int'(bus.Prog_Len), 0);
      chk("midrst_mem_we", int'(bus.Mem_WE), 0);
      chk("midrst_load_ready", int'(bus.Load_Ready), 0);
      ref_state = 0;
      ref_len   = 0;
      @(posedge Clk);
      @(posedge Clk);
      #1 clear_inputs();
      Reset_n = 1'b1;
      gap_cycle(1'b1, 1'b1);

      // Randomized load/fetch sessions
      for (int it = 0; it < 20; it++) begin
         load_start(($urandom_range(0, 1) == 1) && (ref_state == 2));
         n = $urandom_range(0, DEPTH);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) gap_cycle(1'b0, 1'b1);
            load_byte(8'($urandom_range(0, 255)), (i == n - 1) && (n < DEPTH) && ($urandom_range(0, 1) == 1));
         end
         if (ref_state == 1) load_done_only();
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 2) == 0) gap_cycle(1'b1, 1'b0);
            fetch(8'($urandom_range(0, 23)));
         end
         bus.Fetch_Req = 1'b0;
      end

      gap_cycle(1'b0, 1'b0);
      gap_cycle(1'b0, 1'b0);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_load_ctrl.md
FETCH_LOAD_CTRL -- requirements
Module: fetch_load_ctrl

Interface
REQ-001 SHALL have parameters: DEPTH, 16, instruction memory entries; ADDR_W, 4, memory address width (2^ADDR_W == DEPTH).
REQ-002 SHALL have ports:
- Clk  in  1  sole clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Load_Start  in  1  pulse; begin program load.
- Load_Valid  in  1  Load_Data is valid.
- Load_Data  in  8  program byte.
- Load_Ready  out  1  controller accepts a byte this cycle.
- Load_Done  in  1  pulse; end program load.
- Fetch_Req  in  1  core requests an instruction.
- Fetch_PC  in  8  core program counter.
- Fetch_Ready  out  1  fetch is accepted this cycle.
- Fetch_Valid  out  1  Fetch_Instr is valid.
- Fetch_Instr  out  8  fetched instruction byte.
- Fetch_Err  out  1  out-of-range fetch flag.
- Mem_Addr  out  ADDR_W  instruction memory address.
- Mem_WData  out  8  memory write data.
- Mem_WE  out  1  memory write enable.
- Mem_RData  in  8  combinational memory read data.
- Prog_Len  out  ADDR_W+1  count of loaded bytes.
- State  out  2  IDLE=00, LOAD=01, RUN=10.

Function
REQ-003 SHALL implement FSM IDLE/LOAD/RUN; Load_Start in any state -> LOAD next edge, Prog_Len cleared to 0.
REQ-004 SHALL assert Load_Ready = (State==LOAD) & ~Load_Start; a byte is written when Load_Valid & Load_Ready.
REQ-005 SHALL, on a write, drive Mem_WE=1, Mem_Addr=Prog_Len[ADDR_W-1:0], Mem_WData=Load_Data combinationally, and increment Prog_Len at the edge.
REQ-006 SHALL go LOAD -> RUN on Load_Done, or automatically when the write that makes Prog_Len==DEPTH completes.
REQ-007 SHALL, with Load_Valid and Load_Done in the same cycle, write that byte first, then enter RUN.
REQ-008 SHALL go LOAD -> RUN with Prog_Len=0 on Load_Done and no prior bytes.
REQ-009 SHALL assert Fetch_Ready = (State==RUN) & ~Load_Start; Load_Start has priority over Fetch_Req.
REQ-010 SHALL drive Mem_Addr=Fetch_PC[ADDR_W-1:0] and Mem_WE=0 in RUN and IDLE.
REQ-011 SHALL, on accepted fetch at edge N, register Fetch_Instr=Mem_RData and set Fetch_Valid=1 from edge N to N+1 (one-cycle latency, one-cycle pulse); back-to-back fetches every cycle are supported.
REQ-012 SHALL hold Fetch_Instr at its last value when Fetch_Valid=0.
REQ-013 SHALL never assert Mem_WE outside LOAD.
REQ-014 SHALL clear Fetch_Valid on the edge where Load_Start is sampled, even if a fetch was pending.

Reset
REQ-015 SHALL, while Reset_n=0, asynchronously force State=IDLE, Prog_Len=0, Fetch_Valid=0, Fetch_Instr=8'h00, Fetch_Err=0; combinational outputs follow (Load_Ready=0, Fetch_Ready=0, Mem_WE=0).
REQ-016 SHALL abandon a load in progress on reset; memory contents are not cleared.

Configuration
REQ-017 SHALL honour macro IMEM_BOUNDS_CHECK_EN.
REQ-018 SHALL, when defined, return Fetch_Instr=8'h00 with Fetch_Err=1 (same cycle as Fetch_Valid) for an accepted fetch with Fetch_PC >= Prog_Len; otherwise Fetch_Err=0.
REQ-019 SHALL, when undefined, tie Fetch_Err=0 and fetch Mem_RData at Fetch_PC[ADDR_W-1:0] (wrap-around) with no range check.

Verification
REQ-020 SHALL cover: reset, Load_Start, bytes 2B,6A,63,C1,14,55 then Load_Done -> Mem_WE at addr 0..5, Prog_Len=6, State=RUN.
REQ-021 SHALL cover: fetch PC=0..5 every cycle -> Fetch_Valid each following cycle, Fetch_Instr 2B,6A,63,C1,14,55.
REQ-022 SHALL cover: 16 bytes without Load_Done -> RUN after 16th write, Prog_Len=16, Load_Ready=0.
REQ-023 SHALL cover: Fetch_Req and Load_Start same cycle in RUN -> Fetch_Ready=0, no Fetch_Valid, State=LOAD, Prog_Len=0.
REQ-024 SHALL cover: Prog_Len=6, fetch PC=8'h09 -> with macro 00 and Fetch_Err=1; without macro Mem[9] and Fetch_Err=0.
REQ-025 SHALL cover: Reset_n low mid-load after 3 bytes -> immediate IDLE, Prog_Len=0, Mem_WE=0.
